// File: rtl/mac_tx_arbiter_if.sv
// Bundle of the requester-side and GMII-side signals of the TX arbiter.
// The i_/o_ prefixes are named from the arbiter's point of view.
interface mac_tx_arbiter_if;
    logic [2:0] i_req;
    logic [7:0] i_data0;
    logic [7:0] i_data1;
    logic [7:0] i_data2;
    logic       i_valid0;
    logic       i_valid1;
    logic       i_valid2;
    logic [2:0] o_grant;
    logic [7:0] o_GMII_data;
    logic       o_GMII_valid;
    logic       o_busy;
    logic       o_trunc;
    logic       o_timeout;

    // Requesters plus the frame-buffer side, i.e. whoever drives the arbiter.
    modport master (
        output i_req, i_data0, i_data1, i_data2, i_valid0, i_valid1, i_valid2,
        input  o_grant, o_GMII_data, o_GMII_valid, o_busy, o_trunc, o_timeout
    );

    // The arbiter itself.
    modport slave (
        input  i_req, i_data0, i_data1, i_data2, i_valid0, i_valid1, i_valid2,
        output o_grant, o_GMII_data, o_GMII_valid, o_busy, o_trunc, o_timeout
    );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter that merges the ARP, ICMP and UDP byte streams into a
// single GMII transmit stream, with inter-frame gap, length truncation and a
// grant timeout for requesters that never start their frame.
module mac_tx_arbiter #(
    parameter int P_GAP     = 12,
    parameter int P_MAX_LEN = 1514,
    parameter int P_TIMEOUT = 64
) (
    input  logic            i_udp_stack_clk,
    input  logic            i_rst_n,
    mac_tx_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_XFER,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(P_TIMEOUT - 1);
    localparam logic [15:0] LP_GAP_LAST     = 16'(P_GAP - 1);
    localparam logic [10:0] LP_MAX_LEN      = 11'(P_MAX_LEN);

    // Requester index 0..2 advanced by one with wrap-around.
    function automatic logic [1:0] nextIdx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] oneHot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    state_t      r_state;
    logic [2:0]  r_grant;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic [15:0] r_cycCnt;
    logic [10:0] r_byteCnt;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_trunc;
    logic        r_timeout;

    state_t      w_state;
    logic [2:0]  w_grant;
    logic [1:0]  w_idx;
    logic [1:0]  w_last;
    logic [15:0] w_cycCnt;
    logic [10:0] w_byteCnt;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_trunc;
    logic        w_timeout;

    logic        w_selValid;
    logic [7:0]  w_selData;
    logic [1:0]  w_c0;
    logic [1:0]  w_c1;
    logic [1:0]  w_c2;
    logic [1:0]  w_winIdx;

    // Search order starts one past the last winner, so every requester gets
    // its turn even when all three keep their request asserted.
    assign w_c0     = nextIdx(r_last);
    assign w_c1     = nextIdx(w_c0);
    assign w_c2     = nextIdx(w_c1);
    assign w_winIdx = bus.i_req[w_c0] ? w_c0 : (bus.i_req[w_c1] ? w_c1 : w_c2);

    // Only the current grantee's stream is looked at; the others are dropped.
    always_comb begin
        w_selValid = 1'b0;
        w_selData  = 8'd0;
        case (r_idx)
            2'd0: begin
                w_selValid = bus.i_valid0;
                w_selData  = bus.i_data0;
            end
            2'd1: begin
                w_selValid = bus.i_valid1;
                w_selData  = bus.i_data1;
            end
            default: begin
                w_selValid = bus.i_valid2;
                w_selData  = bus.i_data2;
            end
        endcase
    end

    // Next-state and next-output logic; data defaults to zero so the GMII byte
    // is clean whenever valid is low.
    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_idx     = r_idx;
        w_last    = r_last;
        w_cycCnt  = r_cycCnt;
        w_byteCnt = r_byteCnt;
        w_data    = 8'd0;
        w_valid   = 1'b0;
        w_trunc   = 1'b0;
        w_timeout = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant = 3'b000;
                if (bus.i_req != 3'b000) begin
                    w_idx     = w_winIdx;
                    w_last    = w_winIdx;
                    w_grant   = oneHot(w_winIdx);
                    w_cycCnt  = 16'd0;
                    w_byteCnt = 11'd0;
                    w_state   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_selValid) begin
                    w_valid   = 1'b1;
                    w_data    = w_selData;
                    w_byteCnt = 11'd1;
                    w_state   = ST_XFER;
                end else if (r_cycCnt == LP_TIMEOUT_LAST) begin
                    w_timeout = 1'b1;
                    w_grant   = 3'b000;
                    w_state   = ST_IDLE;
                end else begin
                    w_cycCnt = r_cycCnt + 16'd1;
                end
            end
            ST_XFER: begin
                if (w_selValid) begin
                    if (r_byteCnt == LP_MAX_LEN) begin
                        w_trunc = 1'b1;
                        w_state = ST_DRAIN;
                    end else begin
                        w_valid   = 1'b1;
                        w_data    = w_selData;
                        w_byteCnt = r_byteCnt + 11'd1;
                    end
                end else begin
                    w_grant  = 3'b000;
                    w_cycCnt = 16'd0;
                    w_state  = ST_GAP;
                end
            end
            ST_DRAIN: begin
                if (!w_selValid) begin
                    w_grant  = 3'b000;
                    w_cycCnt = 16'd0;
                    w_state  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cycCnt == LP_GAP_LAST) begin
                    w_state = ST_IDLE;
                end else begin
                    w_cycCnt = r_cycCnt + 16'd1;
                end
            end
            default: begin
                w_grant = 3'b000;
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forgets any partial frame and makes
    // requester 0 the first to be served.
    always_ff @(posedge i_udp_stack_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 3'b000;
            r_idx     <= 2'd0;
            r_last    <= 2'd2;
            r_cycCnt  <= 16'd0;
            r_byteCnt <= 11'd0;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_trunc   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_idx     <= w_idx;
            r_last    <= w_last;
            r_cycCnt  <= w_cycCnt;
            r_byteCnt <= w_byteCnt;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_busy    <= (w_state != ST_IDLE);
            r_trunc   <= w_trunc;
            r_timeout <= w_timeout;
        end
    end

    assign bus.o_grant      = r_grant;
    assign bus.o_GMII_data  = r_data;
    assign bus.o_GMII_valid = r_valid;
    assign bus.o_busy       = r_busy;
    assign bus.o_trunc      = r_trunc;
    assign bus.o_timeout    = r_timeout;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: a table of arbitration/frame
// vectors, hand-written timeout and reset sequences, then random frames
// checked against a round-robin reference model.
module tb_mac_tx_arbiter;

    localparam int P_GAP     = 12;
    localparam int P_MAX_LEN = 1514;
    localparam int P_TIMEOUT = 64;

    typedef struct {
        logic [2:0] req;
        logic [2:0] expGrant;
        int         len;
        int         delay;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelLast;
    bit   monActive   = 1'b0;
    bit   scrambleReq = 1'b0;

    mac_tx_arbiter_if bus ();

    mac_tx_arbiter #(
        .P_GAP     (P_GAP),
        .P_MAX_LEN (P_MAX_LEN),
        .P_TIMEOUT (P_TIMEOUT)
    ) dut (
        .i_udp_stack_clk (clk),
        .i_rst_n         (rstN),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Records one comparison and reports it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Round-robin rule: first requesting index after the previous winner.
    function automatic int modelPick(input logic [2:0] req, input int last);
        for (int s = 1; s <= 3; s++) begin
            if (req[(last + s) % 3]) return (last + s) % 3;
        end
        return -1;
    endfunction

    function automatic int ohIdx(input logic [2:0] g);
        return g[1] ? 1 : (g[2] ? 2 : 0);
    endfunction

    // Drives the chosen channel as given and random traffic on the other two.
    task automatic driveChannels(input int who, input logic ownValid, input logic [7:0] ownData);
        logic [7:0] d [3];
        logic       v [3];
        for (int c = 0; c < 3; c++) begin
            if (c == who) begin
                d[c] = ownData;
                v[c] = ownValid;
            end else begin
                d[c] = 8'($urandom);
                v[c] = 1'($urandom);
            end
        end
        bus.i_data0  = d[0];
        bus.i_data1  = d[1];
        bus.i_data2  = d[2];
        bus.i_valid0 = v[0];
        bus.i_valid1 = v[1];
        bus.i_valid2 = v[2];
    endtask

    // Waits (bounded) for a grant and checks it is the expected one.
    task automatic waitGrant(input logic [2:0] expG);
        int n = 0;
        while (bus.o_grant == 3'b000 && n < 50) begin
            driveChannels(ohIdx(expG), 1'b0, 8'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("grantSeen", 32'(bus.o_grant != 3'b000), 32'd1);
        checkOutput("grant", 32'(bus.o_grant), 32'(expG));
        checkOutput("busyInGrant", 32'(bus.o_busy), 32'd1);
    endtask

    // Sends one frame from the granted channel, checking the one-cycle
    // forwarding, truncation, the end of frame and the inter-frame gap.
    task automatic sendFrame(input int who, input int len, input int delay);
        logic [7:0] b;
        logic [2:0] ownGrant;
        int         truncSeen = 0;
        int         gapCnt    = 0;
        ownGrant = 3'(1 << who);
        for (int d = 0; d < delay; d++) begin
            driveChannels(who, 1'b0, 8'd0);
            @(negedge clk);
            checkOutput("preFrameValid", 32'(bus.o_GMII_valid), 32'd0);
            checkOutput("preFrameGrant", 32'(bus.o_grant), 32'(ownGrant));
        end
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            driveChannels(who, 1'b1, b);
            if (scrambleReq) bus.i_req = 3'($urandom);
            @(negedge clk);
            if (bus.o_trunc) truncSeen++;
            checkOutput("grantHeld", 32'(bus.o_grant), 32'(ownGrant));
            if (k < P_MAX_LEN) begin
                checkOutput("fwdValid", 32'(bus.o_GMII_valid), 32'd1);
                checkOutput("fwdData", 32'(bus.o_GMII_data), 32'(b));
            end else begin
                checkOutput("drainValid", 32'(bus.o_GMII_valid), 32'd0);
                checkOutput("drainData", 32'(bus.o_GMII_data), 32'd0);
            end
        end
        driveChannels(who, 1'b0, 8'($urandom));
        @(negedge clk);
        if (bus.o_trunc) truncSeen++;
        checkOutput("frameEndValid", 32'(bus.o_GMII_valid), 32'd0);
        checkOutput("gapGrantCleared", 32'(bus.o_grant), 32'd0);
        checkOutput("truncPulses", 32'(truncSeen), (len > P_MAX_LEN) ? 32'd1 : 32'd0);
        while (bus.o_busy && gapCnt < 200) begin
            driveChannels(who, 1'b0, 8'd0);
            @(negedge clk);
            gapCnt++;
            checkOutput("gapValid", 32'(bus.o_GMII_valid), 32'd0);
        end
        checkOutput("gapLength", 32'(gapCnt), 32'(P_GAP));
    endtask

    // One full arbitration round followed by a frame from the winner.
    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] expG,
                                 input int len, input int delay);
        bus.i_req = req;
        waitGrant(expG);
        modelLast = ohIdx(expG);
        sendFrame(ohIdx(expG), len, delay);
    endtask

    // Grant must never be multi-hot and the GMII byte must be clean when idle.
    always @(negedge clk) begin
        if (monActive) begin
            checkOutput("grantOneHot", 32'($countones(bus.o_grant) <= 1), 32'd1);
            if (!bus.o_GMII_valid) checkOutput("idleDataZero", 32'(bus.o_GMII_data), 32'd0);
        end
    end

    // Keeps the run bounded even if the design stalls.
    initial begin
        #5ms;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        vec_t       vecs [11];
        logic [2:0] req;
        logic [7:0] b;
        int         cnt;
        int         w;

        vecs[0]  = '{3'b111, 3'b001,   60, 0};
        vecs[1]  = '{3'b111, 3'b010,   60, 1};
        vecs[2]  = '{3'b111, 3'b100,   60, 2};
        vecs[3]  = '{3'b111, 3'b001,   60, 0};
        vecs[4]  = '{3'b100, 3'b100,  100, 0};
        vecs[5]  = '{3'b110, 3'b010,   20, 3};
        vecs[6]  = '{3'b011, 3'b001,   15, 1};
        vecs[7]  = '{3'b101, 3'b100,   10, 0};
        vecs[8]  = '{3'b010, 3'b010,    5, 2};
        vecs[9]  = '{3'b010, 3'b010,    1, 0};
        vecs[10] = '{3'b001, 3'b001, 1600, 0};

        rstN         = 1'b0;
        bus.i_req    = 3'b000;
        bus.i_data0  = 8'd0;
        bus.i_data1  = 8'd0;
        bus.i_data2  = 8'd0;
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        bus.i_valid2 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstGrant", 32'(bus.o_grant), 32'd0);
        checkOutput("rstData", 32'(bus.o_GMII_data), 32'd0);
        checkOutput("rstValid", 32'(bus.o_GMII_valid), 32'd0);
        checkOutput("rstBusy", 32'(bus.o_busy), 32'd0);
        checkOutput("rstTrunc", 32'(bus.o_trunc), 32'd0);
        checkOutput("rstTimeout", 32'(bus.o_timeout), 32'd0);
        rstN      = 1'b1;
        monActive = 1'b1;
        modelLast = 2;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].req, vecs[i].expGrant, vecs[i].len, vecs[i].delay);
        end

        // Grantee never starts: grant is revoked and the next request is served at once.
        bus.i_req = 3'b110;
        waitGrant(3'b010);
        modelLast = 1;
        cnt = 0;
        while (bus.o_grant == 3'b010 && cnt < 200) begin
            driveChannels(1, 1'b0, 8'd0);
            @(negedge clk);
            cnt++;
            if (bus.o_grant == 3'b010) checkOutput("noEarlyTimeout", 32'(bus.o_timeout), 32'd0);
        end
        checkOutput("timeoutGrantCycles", 32'(cnt), 32'(P_TIMEOUT));
        checkOutput("timeoutPulse", 32'(bus.o_timeout), 32'd1);
        checkOutput("timeoutGrantCleared", 32'(bus.o_grant), 32'd0);
        driveChannels(2, 1'b0, 8'd0);
        @(negedge clk);
        checkOutput("timeoutSinglePulse", 32'(bus.o_timeout), 32'd0);
        checkOutput("regrantNoGap", 32'(bus.o_grant), 32'b100);
        modelLast = 2;
        sendFrame(2, 8, 0);

        // Reset at byte 30 of a frame: outputs clear and the frame never resumes.
        bus.i_req = 3'b110;
        waitGrant(3'b010);
        modelLast = 1;
        bus.i_req = 3'b000;
        for (int k = 0; k < 30; k++) begin
            b = 8'($urandom);
            driveChannels(1, 1'b1, b);
            @(negedge clk);
            checkOutput("preRstValid", 32'(bus.o_GMII_valid), 32'd1);
            checkOutput("preRstData", 32'(bus.o_GMII_data), 32'(b));
        end
        driveChannels(1, 1'b1, 8'hA5);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midRstGrant", 32'(bus.o_grant), 32'd0);
        checkOutput("midRstData", 32'(bus.o_GMII_data), 32'd0);
        checkOutput("midRstValid", 32'(bus.o_GMII_valid), 32'd0);
        checkOutput("midRstBusy", 32'(bus.o_busy), 32'd0);
        checkOutput("midRstTrunc", 32'(bus.o_trunc), 32'd0);
        checkOutput("midRstTimeout", 32'(bus.o_timeout), 32'd0);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            driveChannels(1, 1'b1, 8'($urandom));
            @(negedge clk);
            checkOutput("noResumeValid", 32'(bus.o_GMII_valid), 32'd0);
            checkOutput("noResumeGrant", 32'(bus.o_grant), 32'd0);
        end
        applyStimulus(3'b111, 3'b001, 12, 1);

        // Random requests and frame shapes against the round-robin model.
        scrambleReq = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req = 3'($urandom_range(1, 7));
            w   = modelPick(req, modelLast);
            applyStimulus(req, 3'(1 << w), $urandom_range(1, 40), $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
